// File: rtl/instr_fetch_seq_pkg.sv
// Shared definitions for the instruction fetch/sequencer slice: field layout,
// HALT opcode and sequencer state encoding.
package cpu_pkg;

    localparam int INSTR_W = 19;
    localparam int RES_W   = 8;

    localparam int OPC_MSB = 18;
    localparam int OPC_LSB = 16;
    localparam int A_MSB   = 15;
    localparam int A_LSB   = 8;
    localparam int B_MSB   = 7;
    localparam int B_LSB   = 0;

    localparam logic [2:0] OPC_HALT = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Valid/ready instruction channel between the fetch stage (master) and the CU
// (slave); the CU returns its result combinationally on the same channel.
interface instr_fetch_seq_if #(
    parameter int INSTR_W = 19,
    parameter int RES_W   = 8
);
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [RES_W-1:0]   result_in;

    modport master (
        output instr,
        output instr_valid,
        input  instr_ready,
        input  result_in
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output instr_ready,
        output result_in
    );
endinterface

// File: rtl/instr_fetch_seq_prog_mem.sv
// Program store: register array with asynchronous clear, synchronous write
// and combinational read.
module prog_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_seq.sv
// Fetch/sequencer stage: walks the program memory and hands one instruction
// at a time to the CU, capturing the CU result on each accept.
module instr_fetch_seq #(
    parameter int INSTR_W = 19,
    parameter int RES_W   = 8,
    parameter int ADDR_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_en,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [INSTR_W-1:0]  load_data,
    input  logic [ADDR_W:0]     prog_len,
    input  logic                start,
    instr_fetch_seq_if.master   cu,
    output logic [RES_W-1:0]    last_result,
    output logic                result_valid,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     issued_cnt
);
    import cpu_pkg::*;

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH = LEN_W'(2 ** ADDR_W);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [RES_W-1:0]   last_res_q, last_res_d;
    logic               res_valid_q, res_valid_d;
    logic               done_q, done_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;

    logic [INSTR_W-1:0] mem_rdata;
    logic [LEN_W-1:0]   len_clamped;
    logic               mem_we;

    // Writes are only honoured while idle so a running program is never altered.
    assign mem_we      = load_en && (state_q == ST_IDLE);
    assign len_clamped = (prog_len > DEPTH) ? DEPTH : prog_len;

    prog_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (INSTR_W)
    ) u_prog_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (pc_q),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            last_res_q  <= '0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            last_res_q  <= last_res_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        last_res_d  = last_res_q;
        res_valid_d = 1'b0;
        done_d      = 1'b0;
        cnt_d       = cnt_q;
        len_d       = len_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    len_d = len_clamped;
                    if (len_clamped != '0) begin
                        pc_d    = '0;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                instr_d = mem_rdata;
                if (mem_rdata[OPC_MSB:OPC_LSB] == OPC_HALT) begin
                    state_d = ST_DONE;
                end else begin
                    valid_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cu.instr_ready) begin
                    last_res_d  = cu.result_in;
                    res_valid_d = 1'b1;
                    cnt_d       = cnt_q + LEN_W'(1);
                    valid_d     = 1'b0;
                    if ({1'b0, pc_q} == len_q - LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cu.instr        = instr_q;
    assign cu.instr_valid  = valid_q;
    assign last_result     = last_res_q;
    assign result_valid    = res_valid_q;
    assign pc              = pc_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign issued_cnt      = cnt_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed self-checking bench for instr_fetch_seq with a simple CU stub.
module tb_instr_fetch_seq;

    logic        clk;
    logic        rst_n;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [18:0] load_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        ready;
    logic        cu_ovr;
    logic [7:0]  last_result;
    logic        result_valid;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic [4:0]  issued_cnt;

    int n_checks;
    int n_fail;

    // Observations collected by run_prog
    int          n_pulse;
    logic [18:0] seen_instr [16];
    int          pulse_off  [16];
    int          n_rv;
    logic [7:0]  rv_res     [16];
    int          n_done;
    int          done_off;
    logic [4:0]  cnt_at_done;
    logic [3:0]  pc_at_done;
    logic        busy_off1;
    bit          unstable;

    instr_fetch_seq_if #(.INSTR_W(19), .RES_W(8)) cu_if ();

    // CU stub: result = A + B + opcode, or junk while a stall is forced
    assign cu_if.instr_ready = ready;
    assign cu_if.result_in   = cu_ovr ? 8'hA5 :
                               (cu_if.instr[15:8] + cu_if.instr[7:0] + {5'b0, cu_if.instr[18:16]});

    instr_fetch_seq #(.INSTR_W(19), .RES_W(8), .ADDR_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .prog_len     (prog_len),
        .start        (start),
        .cu           (cu_if),
        .last_result  (last_result),
        .result_valid (result_valid),
        .pc           (pc),
        .busy         (busy),
        .done         (done),
        .issued_cnt   (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] word(input int unsigned opc);
        logic [2:0] o;
        o = opc[2:0];
        return {o, 8'h23, 8'h14};
    endfunction

    task automatic load_word(input logic [3:0] a, input logic [18:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic load_program();
        for (int unsigned i = 0; i < 7; i++) load_word(4'(i), word(i + 1));
    endtask

    // Starts a program and records what the DUT does, sampling on negedges.
    task automatic run_prog(input logic [4:0] len, input int stall_k, input int stall_n, input bit inject);
        int          stalled;
        logic        pv;
        logic [18:0] sinstr;
        n_pulse = 0; n_rv = 0; n_done = 0; done_off = -1; unstable = 0;
        stalled = 0; pv = 1'b0; sinstr = '0; busy_off1 = 1'b0;
        cnt_at_done = '0; pc_at_done = '0;
        @(negedge clk);
        prog_len = len; start = 1'b1; ready = 1'b1; cu_ovr = 1'b0;
        for (int off = 1; off <= 80; off++) begin
            @(negedge clk);
            if (off == 1) begin start = 1'b0; busy_off1 = busy; end
            if (cu_if.instr_valid && !pv && n_pulse < 16) begin
                seen_instr[n_pulse] = cu_if.instr;
                pulse_off[n_pulse]  = off;
                n_pulse++;
            end
            if (result_valid && n_rv < 16) begin rv_res[n_rv] = last_result; n_rv++; end
            if (done) begin
                if (n_done == 0) begin done_off = off; cnt_at_done = issued_cnt; pc_at_done = pc; end
                n_done++;
            end
            if (cu_if.instr_valid && n_pulse == stall_k && stalled > 0 && cu_if.instr !== sinstr) unstable = 1;
            if (cu_if.instr_valid && n_pulse == stall_k && stalled < stall_n) begin
                if (stalled == 0) sinstr = cu_if.instr;
                ready = 1'b0; cu_ovr = 1'b1; stalled++;
            end else begin
                ready = 1'b1; cu_ovr = 1'b0;
            end
            if (inject && off == 5) begin
                load_en = 1'b1; load_addr = 4'd1; load_data = 19'h7FFFF; start = 1'b1;
            end else if (inject && off == 6) begin
                load_en = 1'b0; start = 1'b0;
            end
            pv = cu_if.instr_valid;
            if (n_done > 0 && off >= done_off + 2) break;
        end
        ready = 1'b1; cu_ovr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++; if (cu_if.instr !== 19'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", cu_if.instr); end
        n_checks++; if (cu_if.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", cu_if.instr_valid); end
        n_checks++; if (last_result !== 8'h0) begin n_fail++; $display("FAIL reset_last_result: got %h want 0", last_result); end
        n_checks++; if ({result_valid, done, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got rv/done/busy=%b want 000", {result_valid, done, busy}); end
        n_checks++; if ({pc, issued_cnt} !== 9'h0) begin n_fail++; $display("FAIL reset_pc_cnt: got pc=%0d cnt=%0d want 0 0", pc, issued_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        load_program();
        run_prog(5'd7, 0, 0, 1'b0);
        n_checks++; if (n_pulse !== 7) begin n_fail++; $display("FAIL basic_pulses: got %0d want 7", n_pulse); end
        for (int k = 0; k < 7; k++) begin
            n_checks++; if (seen_instr[k] !== word(k + 1)) begin n_fail++; $display("FAIL basic_instr%0d: got %h want %h", k, seen_instr[k], word(k + 1)); end
            n_checks++; if (pulse_off[k] !== 2 + 2 * k) begin n_fail++; $display("FAIL basic_timing%0d: got cycle %0d want %0d", k, pulse_off[k], 2 + 2 * k); end
            n_checks++; if (rv_res[k] !== 8'(8'h38 + k)) begin n_fail++; $display("FAIL basic_result%0d: got %h want %h", k, rv_res[k], 8'(8'h38 + k)); end
        end
        n_checks++; if (n_rv !== 7) begin n_fail++; $display("FAIL basic_rv_count: got %0d want 7", n_rv); end
        n_checks++; if (n_done !== 1 || done_off !== 16) begin n_fail++; $display("FAIL basic_done: got count %0d at %0d want 1 at 16", n_done, done_off); end
        n_checks++; if (cnt_at_done !== 5'd7) begin n_fail++; $display("FAIL basic_issued: got %0d want 7", cnt_at_done); end
        n_checks++; if (pc_at_done !== 4'd6) begin n_fail++; $display("FAIL basic_pc_end: got %0d want 6", pc_at_done); end
    endtask

    task automatic test_stall();
        run_prog(5'd7, 3, 5, 1'b0);
        n_checks++; if (unstable !== 1'b0) begin n_fail++; $display("FAIL stall_stable: instr changed=%b want 0", unstable); end
        n_checks++; if (n_pulse !== 7) begin n_fail++; $display("FAIL stall_pulses: got %0d want 7", n_pulse); end
        n_checks++; if (pulse_off[3] !== 13) begin n_fail++; $display("FAIL stall_resume: got cycle %0d want 13", pulse_off[3]); end
        n_checks++; if (n_rv !== 7) begin n_fail++; $display("FAIL stall_rv_count: got %0d want 7", n_rv); end
        n_checks++; if (rv_res[2] !== 8'h3A) begin n_fail++; $display("FAIL stall_capture: got %h want 3a", rv_res[2]); end
        n_checks++; if (done_off !== 21 || cnt_at_done !== 5'd7) begin n_fail++; $display("FAIL stall_done: got at %0d cnt %0d want 21 cnt 7", done_off, cnt_at_done); end
    endtask

    task automatic test_busy_ignore();
        run_prog(5'd7, 0, 0, 1'b1);
        n_checks++; if (n_pulse !== 7 || done_off !== 16 || n_done !== 1) begin n_fail++; $display("FAIL busy_seq: got %0d pulses done %0d@%0d want 7, 1@16", n_pulse, n_done, done_off); end
        n_checks++; if (seen_instr[1] !== word(2)) begin n_fail++; $display("FAIL busy_instr1: got %h want %h", seen_instr[1], word(2)); end
        run_prog(5'd7, 0, 0, 1'b0);
        n_checks++; if (seen_instr[1] !== word(2)) begin n_fail++; $display("FAIL busy_mem_kept: got %h want %h", seen_instr[1], word(2)); end
        n_checks++; if (cnt_at_done !== 5'd7) begin n_fail++; $display("FAIL busy_issued: got %0d want 7", cnt_at_done); end
    endtask

    task automatic test_halt();
        load_word(4'd2, 19'h0);
        run_prog(5'd5, 0, 0, 1'b0);
        n_checks++; if (n_pulse !== 2) begin n_fail++; $display("FAIL halt_pulses: got %0d want 2", n_pulse); end
        n_checks++; if (n_done !== 1 || done_off !== 7) begin n_fail++; $display("FAIL halt_done: got %0d@%0d want 1@7", n_done, done_off); end
        n_checks++; if (cnt_at_done !== 5'd2) begin n_fail++; $display("FAIL halt_issued: got %0d want 2", cnt_at_done); end
        n_checks++; if (pc_at_done !== 4'd2) begin n_fail++; $display("FAIL halt_pc: got %0d want 2", pc_at_done); end
    endtask

    task automatic test_zero_len();
        run_prog(5'd0, 0, 0, 1'b0);
        n_checks++; if (busy_off1 !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %b want 1", busy_off1); end
        n_checks++; if (n_done !== 1 || done_off !== 2) begin n_fail++; $display("FAIL zero_done: got %0d@%0d want 1@2", n_done, done_off); end
        n_checks++; if (n_pulse !== 0) begin n_fail++; $display("FAIL zero_valid: got %0d pulses want 0", n_pulse); end
        n_checks++; if (cnt_at_done !== 5'd0) begin n_fail++; $display("FAIL zero_issued: got %0d want 0", cnt_at_done); end
    endtask

    task automatic test_reset_mid();
        int   n;
        logic pv;
        bit   found;
        n = 0; pv = 1'b0; found = 0;
        load_word(4'd2, word(3));
        @(negedge clk);
        prog_len = 5'd7; start = 1'b1; ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (cu_if.instr_valid && !pv) n++;
            pv = cu_if.instr_valid;
            if (n == 4) begin found = 1; break; end
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach: got %0d pulses want 4", n); end
        ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (cu_if.instr !== 19'h0 || cu_if.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_instr: got %h/%b want 0/0", cu_if.instr, cu_if.instr_valid); end
        n_checks++; if (last_result !== 8'h0 || result_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_result: got %h/%b want 0/0", last_result, result_valid); end
        n_checks++; if ({busy, done} !== 2'b00 || pc !== 4'd0 || issued_cnt !== 5'd0) begin n_fail++; $display("FAIL rstmid_state: got busy=%b done=%b pc=%0d cnt=%0d want 0", busy, done, pc, issued_cnt); end
        @(negedge clk);
        rst_n = 1'b1; ready = 1'b1;
        run_prog(5'd1, 0, 0, 1'b0);
        n_checks++; if (n_pulse !== 0 || n_done !== 1) begin n_fail++; $display("FAIL rstmid_mem_cleared: got %0d pulses %0d done want 0 1", n_pulse, n_done); end
        load_program();
        run_prog(5'd7, 0, 0, 1'b0);
        n_checks++; if (n_pulse !== 7 || seen_instr[0] !== word(1) || seen_instr[3] !== word(4)) begin n_fail++; $display("FAIL rstmid_rerun: got %0d pulses %h %h want 7 %h %h", n_pulse, seen_instr[0], seen_instr[3], word(1), word(4)); end
        n_checks++; if (cnt_at_done !== 5'd7) begin n_fail++; $display("FAIL rstmid_issued: got %0d want 7", cnt_at_done); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        prog_len = '0; start = 1'b0; ready = 1'b1; cu_ovr = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_busy_ignore();
        test_halt();
        test_zero_len();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
Instruction fetch/sequencer stage that sits directly upstream of the CU. It holds a small program memory of 19-bit instructions, each laid out as opcode[18:16], operand A[15:8] and operand B[7:0]. It issues one instruction at a time to the CU through a valid/ready handshake. It also captures the CU's 8-bit result in the same cycle an instruction is accepted.

Parameters:
INSTR_W, 19, instruction width (opcode 3 + A 8 + B 8)
RES_W, 8, CU result width
ADDR_W, 4, program memory address width (depth 2**ADDR_W = 16)

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_en  in  1  write program word (honoured only in IDLE)
load_addr  in  ADDR_W  program write address
load_data  in  INSTR_W  program write data
prog_len  in  ADDR_W+1  number of instructions to run (0..16)
start  in  1  start pulse (honoured only in IDLE)
instr  out  INSTR_W  instruction presented to CU (registered)
instr_valid  out  1  instr is valid
instr_ready  in  1  CU/downstream accepts instr this cycle
result_in  in  RES_W  CU result for the presented instr (combinational from CU)
last_result  out  RES_W  result captured at the last accepted instr
result_valid  out  1  one-cycle pulse the cycle after capture
pc  out  ADDR_W  current fetch address
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of program
issued_cnt  out  ADDR_W+1  instructions accepted since last start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pc=0; instr=0; instr_valid=0; last_result=0; result_valid=0; done=0; issued_cnt=0; all memory words cleared to 0.
- FSM states: IDLE, FETCH, ISSUE, DONE.
- IDLE:
  - load_en writes mem[load_addr]<=load_data.
  - start with prog_len!=0: pc<=0, issued_cnt<=0, go to FETCH.
  - start with prog_len==0: issued_cnt<=0, go to DONE.
  - If load_en and start are both high, the write happens first. Start still runs, and the written word is visible in FETCH.
- FETCH (1 cycle):
  - instr<=mem[pc].
  - If mem[pc][18:16]==3'b000 (HALT): go to DONE, instr_valid stays 0, nothing is issued.
  - Otherwise: instr_valid<=1, go to ISSUE.
- ISSUE:
  - Hold instr and instr_valid=1 stable until instr_ready=1. No limit on stall length.
  - On accept: last_result<=result_in; result_valid=1 next cycle; issued_cnt++; instr_valid<=0.
  - After accept, if pc==prog_len-1 go to DONE; else pc++ and go to FETCH.
- DONE: done=1 for exactly one cycle, then IDLE. pc holds the last fetched address.
- Throughput: 2 cycles per instruction with instr_ready tied high. start to first instr_valid = 2 cycles.
- Ignored inputs: start and load_en are ignored while busy. Program memory is never modified while running.
- Reset mid-operation returns to IDLE immediately with the reset values above.
- No wrap-around: pc never exceeds prog_len-1. prog_len>16 is clamped to 16.

Decomposition:
- Shared package (cpu_pkg): INSTR_W, RES_W, opcode field positions (OPC_MSB=18, OPC_LSB=16, A 15:8, B 7:0), OPC_HALT=3'b000, FSM state enum.
- One sub-module: prog_mem (2**ADDR_W x INSTR_W register array, async-clear, sync write, combinational read).

Test Plan:
1. Load 7 words with opcodes 001..111 and A=0x23, B=0x14 (e.g. 19'b0010010001100010100); prog_len=7; start; instr_ready=1 -> 7 instr_valid pulses 2 cycles apart, carrying the loaded words in order; done pulse once; issued_cnt=7.
2. Same program with instr_ready held low for 5 cycles on instruction 3 -> instr stays stable for those cycles; the CU model's result is captured only on the accept cycle; result_valid fires exactly once per instruction.
3. mem[2]=19'h0 (HALT), prog_len=5 -> only 2 instructions issued; done pulse; issued_cnt=2; instr_valid never asserted for address 2.
4. prog_len=0 and start -> done 2 cycles after start; instr_valid never asserted; issued_cnt=0.
5. Assert rst_n=0 during ISSUE of instruction 4 -> all outputs zero asynchronously; busy=0; a subsequent start with a reloaded program runs cleanly from pc=0.
6. Pulse load_en and start while busy -> both ignored; memory contents and instruction sequence unchanged.
